// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard id width, write-back port count and the
// exception record carried alongside every result.
package ariane_pkg;

   localparam int unsigned TRANS_ID_BITS = 3;
   localparam int unsigned NR_WB_PORTS   = 2;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

endpackage

// File: rtl/wb_collector_if.sv
// Result-source and scoreboard write-back bundle for the write-back collector.
// The collector uses the slave view; the environment drives the master view.
interface wb_collector_if #(
   parameter int unsigned NR_SRC      = 4,
   parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
);

   logic [NR_SRC-1:0]                                  src_valid_i;
   logic [NR_SRC-1:0][ariane_pkg::TRANS_ID_BITS-1:0]   src_trans_id_i;
   logic [NR_SRC-1:0][63:0]                            src_result_i;
   ariane_pkg::exception_t [NR_SRC-1:0]                src_exception_i;
   logic [NR_SRC-1:0]                                  src_full_o;

   logic [NR_WB_PORTS-1:0]                                wb_valid_o;
   logic [NR_WB_PORTS-1:0]                                wb_ready_i;
   logic [NR_WB_PORTS-1:0][ariane_pkg::TRANS_ID_BITS-1:0] wb_trans_id_o;
   logic [NR_WB_PORTS-1:0][63:0]                          wb_data_o;
   ariane_pkg::exception_t [NR_WB_PORTS-1:0]              wb_ex_o;

   logic overflow_o;

   modport slave (
      input  src_valid_i, src_trans_id_i, src_result_i, src_exception_i, wb_ready_i,
      output src_full_o, wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o, overflow_o
   );

   modport master (
      output src_valid_i, src_trans_id_i, src_result_i, src_exception_i, wb_ready_i,
      input  src_full_o, wb_valid_o, wb_trans_id_o, wb_data_o, wb_ex_o, overflow_o
   );

endinterface

// File: rtl/wb_src_fifo.sv
// Single-source result FIFO: same-edge push, pop from the head, and a flush that
// empties it in one cycle. Storage is unreset; only pointers and count are.
module wb_src_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (int'(ptr) >= int'(DEPTH) - 1) return '0;
      return ptr + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when its head leaves in the same cycle.
   assign push_ok = push_i & (~full_o | pop_i) & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop_i)   rd_ptr_d = next_ptr(rd_ptr_q);
         if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
         case ({push_ok, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/wb_collector.sv
// Collects results from the functional units into per-source FIFOs and hands
// them to the scoreboard write ports with round-robin priority.
module wb_collector #(
   parameter int unsigned NR_SRC      = 4,
   parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input logic           clk_i,
   input logic           rst_i,
   input logic           flush_i,
   wb_collector_if.slave bus
);

   localparam int unsigned SRC_W   = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENTRY_W = ariane_pkg::TRANS_ID_BITS + 64 + $bits(ariane_pkg::exception_t);

   logic [NR_SRC-1:0]              pop, full, empty, drop;
   logic [NR_SRC-1:0][ENTRY_W-1:0] wdata, head;
   logic [NR_SRC-1:0][CNT_W-1:0]   count;

   logic [NR_WB_PORTS-1:0]            port_valid;
   logic [NR_WB_PORTS-1:0][SRC_W-1:0] port_src;
   logic [NR_SRC-1:0]                 taken;
   logic                              assigned;
   logic [SRC_W-1:0]                  grant_idx, pop_idx, last_pop;
   logic                              any_pop;

   logic [SRC_W-1:0]                  rr_q, rr_d;
   logic                              overflow_q, overflow_d;
   logic [NR_WB_PORTS-1:0]            lock_valid_q, lock_valid_d;
   logic [NR_WB_PORTS-1:0][SRC_W-1:0] lock_src_q, lock_src_d;

   function automatic logic [SRC_W-1:0] wrap_idx(input int base, input int offset);
      int v;
      v = base + offset;
      if (v >= int'(NR_SRC)) v = v - int'(NR_SRC);
      return SRC_W'(v);
   endfunction

   always_comb begin
      for (int s = 0; s < int'(NR_SRC); s++) begin
         wdata[s] = {bus.src_trans_id_i[s], bus.src_result_i[s], bus.src_exception_i[s]};
      end
   end

   for (genvar s = 0; s < int'(NR_SRC); s++) begin : g_src
      wb_src_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (ENTRY_W)
      ) i_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (flush_i),
         .push_i  (bus.src_valid_i[s]),
         .pop_i   (pop[s]),
         .data_i  (wdata[s]),
         .data_o  (head[s]),
         .full_o  (full[s]),
         .empty_o (empty[s]),
         .count_o (count[s])
      );
      assign bus.src_full_o[s] = (count[s] == CNT_W'(FIFO_DEPTH));
      assign drop[s] = bus.src_valid_i[s] & full[s] & ~pop[s] & ~flush_i;
   end

   // A port stalled by the scoreboard keeps its source so its payload cannot
   // change under it; free ports take non-empty sources in search order from rr_q.
   always_comb begin
      port_valid = '0;
      port_src   = '0;
      taken      = '0;
      assigned   = 1'b0;
      grant_idx  = '0;
      for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
         if (lock_valid_q[k]) begin
            port_valid[k]        = 1'b1;
            port_src[k]          = lock_src_q[k];
            taken[lock_src_q[k]] = 1'b1;
         end
      end
      for (int i = 0; i < int'(NR_SRC); i++) begin
         grant_idx = wrap_idx(int'(rr_q), i);
         assigned  = 1'b0;
         if (!empty[grant_idx] && !taken[grant_idx]) begin
            for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
               if (!assigned && !port_valid[k]) begin
                  port_valid[k] = 1'b1;
                  port_src[k]   = grant_idx;
                  assigned      = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
         bus.wb_valid_o[k] = port_valid[k];
         {bus.wb_trans_id_o[k], bus.wb_data_o[k], bus.wb_ex_o[k]} = head[port_src[k]];
         if (port_valid[k] && bus.wb_ready_i[k]) pop[port_src[k]] = 1'b1;
      end
   end

   assign bus.overflow_o = overflow_q;

   // Priority restarts just past the popped source that was searched last.
   always_comb begin
      rr_d     = rr_q;
      any_pop  = 1'b0;
      last_pop = '0;
      pop_idx  = '0;
      for (int i = 0; i < int'(NR_SRC); i++) begin
         pop_idx = wrap_idx(int'(rr_q), i);
         if (pop[pop_idx]) begin
            any_pop  = 1'b1;
            last_pop = pop_idx;
         end
      end
      if (any_pop && !flush_i) rr_d = wrap_idx(int'(last_pop), 1);
      overflow_d = overflow_q | (|drop);
      for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
         lock_valid_d[k] = port_valid[k] & ~bus.wb_ready_i[k] & ~flush_i;
         lock_src_d[k]   = port_src[k];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q         <= '0;
         overflow_q   <= 1'b0;
         lock_valid_q <= '0;
         lock_src_q   <= '0;
      end else begin
         rr_q         <= rr_d;
         overflow_q   <= overflow_d;
         lock_valid_q <= lock_valid_d;
         lock_src_q   <= lock_src_d;
      end
   end

endmodule

// File: doc/wb_collector.md
WB_COLLECTOR -- requirements
Module: wb_collector

Interface
REQ-001 SHALL have parameter NR_SRC, default 4, meaning the number of result sources in fixed index order: 0=FLU, 1=load, 2=store, 3=FPU.
REQ-002 SHALL have parameter NR_WB_PORTS, default 2, meaning the number of scoreboard write ports.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, meaning the entries per source FIFO.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 flush_i  in  1  discard all buffered results.
REQ-007 src_valid_i  in  NR_SRC  per-source result valid (no backpressure).
REQ-008 src_trans_id_i  in  NR_SRC x TRANS_ID_BITS  scoreboard entry id per source.
REQ-009 src_result_i  in  NR_SRC x 64  result data per source.
REQ-010 src_exception_i  in  NR_SRC x exception_t  exception per source.
REQ-011 src_full_o  out  NR_SRC  source FIFO holds FIFO_DEPTH entries; issue logic SHALL NOT issue to that unit.
REQ-012 wb_valid_o  out  NR_WB_PORTS  write port k carries a result.
REQ-013 wb_ready_i  in  NR_WB_PORTS  scoreboard accepts port k.
REQ-014 wb_trans_id_o / wb_data_o / wb_ex_o  out  NR_WB_PORTS x (TRANS_ID_BITS / 64 / exception_t)  write-back payload.
REQ-015 overflow_o  out  1  sticky: a push arrived at a full FIFO that was not popped in the same cycle.

Function
REQ-016 Each source SHALL own one FIFO_DEPTH-entry FIFO storing {trans_id, result, exception}, with a count of clog2(FIFO_DEPTH+1) bits.
REQ-017 src_valid_i[s] SHALL push source s on the same rising edge.
REQ-018 There SHALL be no bypass: a result pushed in cycle N is first visible on wb_* in cycle N+1.
REQ-019 Each port SHALL be granted to a distinct non-empty FIFO; if no FIFO is granted to a port, that port's wb_valid_o bit SHALL be 0.
REQ-020 Port 0 SHALL take the first non-empty source searching from rr_q upward with wrap modulo NR_SRC; port 1 SHALL take the next non-empty source after port 0's source.
REQ-021 FIFO s SHALL pop when its granted port has wb_valid_o & wb_ready_i.
REQ-022 wb_* outputs SHALL be combinational from FIFO heads and rr_q.
REQ-023 wb_* outputs SHALL be stable while wb_valid_o=1 and wb_ready_i=0, unless flush_i is asserted.
REQ-024 rr_q SHALL advance to (highest-priority popped source index + 1) mod NR_SRC, where highest-priority means last in search order.
REQ-025 rr_q SHALL be unchanged when nothing pops.
REQ-026 Pop and push on the same FIFO in the same cycle SHALL both be performed; on a full FIFO the count stays FIFO_DEPTH and no overflow is flagged.
REQ-027 Pop and push on an empty FIFO SHALL not occur, because pop requires a non-empty FIFO.
REQ-028 A push to a full FIFO without a same-cycle pop SHALL be dropped and SHALL set overflow_o.
REQ-029 overflow_o SHALL clear only on reset.
REQ-030 src_full_o[s] SHALL be count_q[s]==FIFO_DEPTH, registered-state derived.
REQ-031 flush_i SHALL clear all counts and pointers on the next edge, with priority over same-cycle pushes; pushes in the flush cycle are discarded.
REQ-032 flush_i SHALL leave rr_q and overflow_o unchanged.
REQ-033 Pops completed in the flush cycle (wb_valid_o & wb_ready_i) SHALL count as accepted by the scoreboard.
REQ-034 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-035 Asserting rst_i SHALL immediately set all counts and pointers to 0, rr_q=0, and overflow_o=0.
REQ-036 Hence during reset wb_valid_o=0 and src_full_o=0.
REQ-037 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-038 FIFO data storage SHALL need no reset.
REQ-039 Outputs SHALL be valid from the first edge after rst_i deasserts.

Structure
REQ-040 exception_t, TRANS_ID_BITS and a new constant NR_WB_PORTS SHALL come from ariane_pkg.
REQ-041 The block SHALL define no new package types.
REQ-042 One sub-module wb_src_fifo (single-source FIFO with push, pop, full, empty and count) SHALL be instantiated NR_SRC times.
REQ-043 Grant and round-robin logic SHALL reside in wb_collector.

Verification
REQ-044 Load push trans_id=3, result=0xDEAD_BEEF in cycle 0, wb_ready_i=11 -> cycle 1: wb_valid_o=01, port0 trans_id=3, data=0xDEADBEEF; cycle 2: wb_valid_o=00; rr_q=2.
REQ-045 All four sources push in the same cycle, wb_ready_i=11, rr_q=0 -> next cycle ports carry sources 0,1; then sources 2,3; then idle; rr_q ends 0.
REQ-046 FLU pushes 3 consecutive cycles with wb_ready_i=00 -> src_full_o[0]=1 after the second push; third push dropped; overflow_o=1 and remains 1 after flush.
REQ-047 FPU FIFO full, wb_ready_i=01 with FPU granted, FPU pushes the same cycle -> count stays 2, overflow_o=0, the order of the 2 entries preserved.
REQ-048 Store FIFO holding 1 entry, flush_i=1 with a simultaneous load push -> next cycle all wb_valid_o=0, src_full_o=0.
REQ-049 rst_i pulsed mid-stream with 2 entries buffered -> outputs invalid immediately, overflow_o=0, no stale entries after release.
